odd_parity_serial_tx: RTL and testbench
=======================================

ODD_PARITY_SERIAL_TX -- requirements
Module: odd_parity_serial_tx

Interface
REQ-001 SHALL have parameter: BIT_CYCLES, 4, clock cycles per serial bit (legal 1..255).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports: A, B, C, D  input  1 each  data nibble bits; A sent first, D last.
REQ-005 SHALL have port: LOAD  input  1  request to send nibble A..D.
REQ-006 SHALL have port: FORCE_ERR  input  1  when high at acceptance, sent parity bit is inverted (checker test aid).
REQ-007 SHALL have port: READY  output  1  high when a LOAD is accepted this cycle.
REQ-008 SHALL have port: TX  output  1  serial line; idle level 1.
REQ-009 SHALL have port: BUSY  output  1  high while a frame is on TX.
REQ-010 SHALL have port: DONE  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL transmit frames of 7 bits in order: start(0), A, B, C, D, OP, stop(1), each held for exactly BIT_CYCLES cycles.
REQ-012 SHALL compute OP = NOT(A XOR B XOR C XOR D), so A^B^C^D^OP = 1 (odd parity); OP inverted when FORCE_ERR captured high.
REQ-013 SHALL accept a request on a rising edge where LOAD=1 and READY=1; A..D and FORCE_ERR are registered at that edge; later input changes do not affect the frame.
REQ-014 SHALL ignore LOAD while READY=0 (no queuing, no error).
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on acceptance; START->DATA, DATA->PARITY after 4th data bit, PARITY->STOP, STOP->IDLE, each after BIT_CYCLES cycles in the bit.
REQ-016 SHALL use a cycle counter 0..BIT_CYCLES-1 reset to 0 at each bit boundary, and a 2-bit data index 0..3 wrapping to PARITY after index 3.
REQ-017 SHALL drive TX=0 starting the cycle after the accepting edge; a frame occupies exactly 7*BIT_CYCLES cycles.
REQ-018 SHALL drive READY=1 only in IDLE; BUSY = NOT READY at all times.
REQ-019 SHALL pulse DONE=1 for one cycle, the first cycle after the last stop-bit cycle, coincident with return to IDLE (READY=1, TX=1).
REQ-020 SHALL allow back-to-back frames: LOAD held high yields a new start bit in the cycle after the DONE cycle, giving one idle-high cycle between frames.
REQ-021 SHALL register TX (no combinational path from inputs to TX, READY, BUSY, DONE).
REQ-022 SHALL behave identically for BIT_CYCLES=1 (each bit one cycle, frame 7 cycles).

Reset
REQ-023 SHALL, on any rising edge with RST=1, enter IDLE with TX=1, READY=1, BUSY=0, DONE=0, counters 0, captured data 0.
REQ-024 SHALL abandon an in-progress frame on RST (no stop bit, no DONE); RST has priority over LOAD in the same cycle.
REQ-025 SHALL accept LOAD on the first edge after RST deasserts.

Verification
REQ-026 Reset: RST high 2 cycles, LOAD=1 -> TX=1, READY=1, BUSY=0, DONE=0 throughout; no frame starts.
REQ-027 Basic frame, BIT_CYCLES=4: A..D=1,0,1,1, LOAD 1 cycle -> TX sequence 0,1,0,1,1,0,1 each 4 cycles (28 cycles), DONE one pulse, then TX=1.
REQ-028 Parity all-zero: A..D=0,0,0,0 -> OP=1; FORCE_ERR=1 with same data -> OP=0; checker on receiver flags error only in second case.
REQ-029 Back-to-back: LOAD held high, nibbles 1,1,1,1 then 0,1,0,0 -> frames 0,1,1,1,1,1,1 and 0,0,1,0,0,0,1, exactly one idle cycle between; data changes mid-frame ignored.
REQ-030 Reset mid-frame: RST asserted during DATA bit C -> next cycle TX=1, READY=1, no DONE; new LOAD after release sends a complete correct frame.
REQ-031 BIT_CYCLES=1: A..D=0,1,1,0 -> TX 0,0,1,1,0,1,1 on 7 consecutive cycles; LOAD during BUSY ignored.

Source files
------------

// File: rtl/odd_parity_serial_tx.sv
// odd_parity_serial_tx: serialises a captured nibble as a 7-bit frame
// (start 0, A, B, C, D, odd parity, stop 1). Each bit is held for BIT_CYCLES clocks.
module odd_parity_serial_tx #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic LOAD,
    input  logic FORCE_ERR,
    output logic READY,
    output logic TX,
    output logic BUSY,
    output logic DONE
);

    // Last value of the per-bit cycle counter before moving to the next bit.
    localparam logic [7:0] LastCnt = 8'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [1:0] idx_q;
    logic [3:0] data_q;   // {D, C, B, A}
    logic       par_q;    // parity bit as it will appear on the line
    logic       tx_q;
    logic       ready_q;
    logic       done_q;

    logic       bit_end;
    logic [1:0] idx_nxt;

    // Bit boundary and next data index.
    assign bit_end = (cnt_q == LastCnt);
    assign idx_nxt = idx_q + 2'd1;

    // Frame sequencer; all outputs come straight from registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            data_q  <= 4'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (LOAD) begin
                        state_q <= StStart;
                        data_q  <= {D, C, B, A};
                        par_q   <= ~(A ^ B ^ C ^ D) ^ FORCE_ERR;
                        cnt_q   <= 8'd0;
                        idx_q   <= 2'd0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q   <= 8'd0;
                        idx_q   <= 2'd0;
                        state_q <= StData;
                        tx_q    <= data_q[0];
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= 8'd0;
                        if (idx_q == 2'd3) begin
                            idx_q   <= 2'd0;
                            state_q <= StParity;
                            tx_q    <= par_q;
                        end else begin
                            idx_q <= idx_nxt;
                            tx_q  <= data_q[idx_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        cnt_q   <= 8'd0;
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        cnt_q   <= 8'd0;
                        state_q <= StIdle;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 8'd0;
                    idx_q   <= 2'd0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign READY = ready_q;
    assign BUSY  = ~ready_q;
    assign TX    = tx_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Bench for odd_parity_serial_tx: two lanes (BIT_CYCLES=4 and 1) share stimulus.
// Expected frames are queued at acceptance; per-lane monitors compare on DONE.
module tb_odd_parity_serial_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic load = 1'b1;
    logic ferr = 1'b0;

    logic ready0, tx0, busy0, done0;
    logic ready1, tx1, busy1, done1;

    always #5 clk = ~clk;

    odd_parity_serial_tx #(.BIT_CYCLES(4)) u_dut4 (
        .CLK(clk), .RST(rst), .A(a), .B(b), .C(c), .D(d), .LOAD(load), .FORCE_ERR(ferr),
        .READY(ready0), .TX(tx0), .BUSY(busy0), .DONE(done0)
    );

    odd_parity_serial_tx #(.BIT_CYCLES(1)) u_dut1 (
        .CLK(clk), .RST(rst), .A(a), .B(b), .C(c), .D(d), .LOAD(load), .FORCE_ERR(ferr),
        .READY(ready1), .TX(tx1), .BUSY(busy1), .DONE(done1)
    );

    logic [1:0] rdy_w, tx_w, bsy_w, dn_w;
    assign rdy_w = {ready1, ready0};
    assign tx_w  = {tx1, tx0};
    assign bsy_w = {busy1, busy0};
    assign dn_w  = {done1, done0};

    int total = 0;
    int bad   = 0;

    // Reference model state: cycles of frame remaining, expected DONE, acceptances.
    int   busy_left [2];
    logic exp_done  [2];
    int   acc_cnt   [2];
    // Entry: bit i (0..6) = i-th line bit of the frame, bit 7 = forced-error flag.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    logic        mon_en = 1'b0;
    logic [27:0] cap0, cap1;
    int          n0 = 0, n1 = 0;

    function automatic int bc_of(input int lane);
        return (lane == 0) ? 4 : 1;
    endfunction

    // Frame from first principles: parity chosen so the ones count of data+parity is odd.
    function automatic logic [7:0] make_entry(input logic [3:0] nib, input logic fe);
        int   ones;
        logic op;
        ones = $countones(nib);
        op   = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        if (fe) op = ~op;
        return {fe, 1'b1, op, nib[3], nib[2], nib[1], nib[0], 1'b0};
    endfunction

    task automatic chk(input string name, input int lane, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane%0d: got %b expected %b at %0t", name, lane, act, exp, $time);
        end
    endtask

    task automatic check_frame(input int lane, input logic [27:0] cap, input int n,
                               input bit have, input logic [7:0] ent);
        int         bc;
        bit         ok;
        logic [6:0] rx;
        logic       rx_err;
        bc = bc_of(lane);
        total++;
        if (!have) begin
            bad++;
            $display("FAIL frame lane%0d: DONE with no expected frame at %0t", lane, $time);
            return;
        end
        ok = (n == 7 * bc);
        for (int i = 0; i < 7 * bc; i++) begin
            if (cap[i] !== ent[i / bc]) ok = 1'b0;
        end
        if (!ok) begin
            bad++;
            $display("FAIL frame lane%0d: got samples %b (n=%0d) expected bits %b x%0d at %0t",
                     lane, cap, n, ent[6:0], bc, $time);
        end
        // Receiver-style mid-bit sampling and odd-parity check.
        for (int k = 0; k < 7; k++) rx[k] = cap[k * bc + bc / 2];
        rx_err = (($countones(rx[5:1]) % 2) == 0);
        total++;
        if (rx_err !== ent[7]) begin
            bad++;
            $display("FAIL parity_flag lane%0d: got %b expected %b at %0t",
                     lane, rx_err, ent[7], $time);
        end
    endtask

    // Lane 0 monitor: capture line while busy, score on DONE.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [7:0] ent0;
            bit         have0;
            if (done0) begin
                chk("done_not_busy", 0, busy0, 1'b0);
                chk("done_tx_idle", 0, tx0, 1'b1);
                have0 = (q0.size() > 0);
                ent0  = have0 ? q0.pop_front() : 8'h00;
                check_frame(0, cap0, n0, have0, ent0);
                n0 = 0;
            end else if (busy0) begin
                if (n0 < 28) cap0[n0] = tx0;
                n0++;
            end else begin
                n0 = 0;
            end
        end
    end

    // Lane 1 monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [7:0] ent1;
            bit         have1;
            if (done1) begin
                chk("done_not_busy", 1, busy1, 1'b0);
                chk("done_tx_idle", 1, tx1, 1'b1);
                have1 = (q1.size() > 0);
                ent1  = have1 ? q1.pop_front() : 8'h00;
                check_frame(1, cap1, n1, have1, ent1);
                n1 = 0;
            end else if (busy1) begin
                if (n1 < 28) cap1[n1] = tx1;
                n1++;
            end else begin
                n1 = 0;
            end
        end
    end

    task automatic model_edge(input int lane);
        logic [7:0] ent;
        exp_done[lane] = 1'b0;
        if (rst) begin
            busy_left[lane] = 0;
            if (lane == 0) q0.delete(); else q1.delete();
        end else if (busy_left[lane] > 0) begin
            busy_left[lane]--;
            if (busy_left[lane] == 0) exp_done[lane] = 1'b1;
        end else if (load) begin
            busy_left[lane] = 7 * bc_of(lane);
            acc_cnt[lane]++;
            ent = make_entry({d, c, b, a}, ferr);
            if (lane == 0) q0.push_back(ent); else q1.push_back(ent);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int l = 0; l < 2; l++) begin
            chk("ready", l, rdy_w[l], busy_left[l] == 0);
            chk("busy", l, bsy_w[l], busy_left[l] != 0);
            chk("done", l, dn_w[l], exp_done[l]);
            if (busy_left[l] == 0) chk("idle_tx", l, tx_w[l], 1'b1);
        end
    endtask

    task automatic set_nib(input logic [3:0] nib);
        a = nib[0]; b = nib[1]; c = nib[2]; d = nib[3];
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy_left[0] != 0 || busy_left[1] != 0) && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", guard);
        end
        step();
        step();
    endtask

    initial begin
        int guard;
        int target;
        for (int l = 0; l < 2; l++) begin
            busy_left[l] = 0;
            exp_done[l]  = 1'b0;
            acc_cnt[l]   = 0;
        end

        // Reset held two cycles with LOAD high: nothing may start.
        rst = 1'b1; load = 1'b1; set_nib(4'b1111);
        step();
        mon_en = 1'b1;
        step();

        // Basic frame A..D = 1,0,1,1 accepted on the first edge after reset.
        rst = 1'b0; set_nib(4'b1101); ferr = 1'b0; load = 1'b1;
        step();
        load = 1'b0; set_nib(4'b0000);
        wait_idle();

        // All-zero nibble, clean then with forced parity error.
        set_nib(4'b0000); ferr = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        wait_idle();
        ferr = 1'b1; load = 1'b1;
        step();
        load = 1'b0; ferr = 1'b0;
        wait_idle();

        // Back-to-back with LOAD held; data changed mid-frame must not leak in.
        set_nib(4'b1111); load = 1'b1;
        step();
        set_nib(4'b0010);
        target = acc_cnt[0] + 1;
        guard = 0;
        while (acc_cnt[0] < target && guard < 100) begin
            step();
            guard++;
        end
        total++;
        if (acc_cnt[0] < target) begin
            bad++;
            $display("FAIL back_to_back: got %0d accepts expected %0d", acc_cnt[0], target);
        end
        load = 1'b0;
        set_nib(4'($urandom));
        step();
        set_nib(4'($urandom));
        wait_idle();

        // Reset during data bit C of the BIT_CYCLES=4 lane, then a clean frame.
        set_nib(4'b0110); load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 13; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0; set_nib(4'b1001); load = 1'b1;
        step();
        load = 1'b0;
        wait_idle();

        // Randomised traffic, including LOAD while busy and occasional resets.
        for (int i = 0; i < 400; i++) begin
            set_nib(4'($urandom));
            ferr = ($urandom_range(0, 3) == 0);
            load = ($urandom_range(0, 2) != 0);
            rst  = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0; ferr = 1'b0;
        wait_idle();

        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL leftover lane0: got %0d frames pending expected 0", q0.size());
        end
        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL leftover lane1: got %0d frames pending expected 0", q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
